// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin front end that shares one uart_tx among NREQ
// byte requesters. It captures the winner's byte, starts the transmitter and
// follows uart_busy to completion. If the transmitter never starts, it flags
// a timeout and moves on.
module uart_tx_arbiter #(
   parameter int NREQ = 4,
   parameter int N    = 8,
   parameter int TOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] data_in,
   input  logic              uart_busy,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   done,
   output logic [N-1:0]      to_uart,
   output logic              tx_external,
   output logic              timeout_err,
   output logic [2:0]        active_id,
   output logic [1:0]        state_out
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] BUSY  = 2'd2;
   localparam logic [1:0] GAP   = 2'd3;

   localparam int            CW       = $clog2(TOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TOUT - 1);
   localparam logic [2:0]    ID_LAST  = 3'(NREQ - 1);

   logic [1:0]    state;
   logic [2:0]    ptr;
   logic [CW-1:0] cnt;
   logic [2:0]    sel;
   logic [2:0]    sel_next;
   logic          any_req;

   // Index (base + off) modulo NREQ, where off < NREQ.
   function automatic logic [2:0] wrap_add(input logic [2:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return 3'(s);
   endfunction

   assign any_req   = |req;
   assign sel_next  = (sel == ID_LAST) ? 3'd0 : sel + 3'd1;
   assign state_out = state;

   // Pick the first requester at or after the pointer. The loop scans
   // downward, so the lowest offset from ptr is the last write and wins.
   always_comb begin
      sel = ptr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[wrap_add(ptr, k)]) sel = wrap_add(ptr, k);
      end
   end

   // Control FSM. All outputs are registered here. The grant, done and
   // timeout_err strobes default low, so each one lasts a single cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ptr         <= '0;
         cnt         <= '0;
         grant       <= '0;
         done        <= '0;
         to_uart     <= '0;
         tx_external <= 1'b0;
         timeout_err <= 1'b0;
         active_id   <= '0;
      end else begin
         grant       <= '0;
         done        <= '0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               // A busy transmitter blocks arbitration. The frame may still
               // be finishing, or the line may still be settling.
               if (!uart_busy && any_req) begin
                  to_uart     <= data_in[int'(sel)*N +: N];
                  active_id   <= sel;
                  grant       <= NREQ'(1) << sel;
                  tx_external <= 1'b1;
                  ptr         <= sel_next;
                  cnt         <= '0;
                  state       <= START;
               end
            end
            START: begin
               if (uart_busy) begin
                  tx_external <= 1'b0;
                  state       <= BUSY;
               end else if (cnt == CNT_LAST) begin
                  tx_external <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BUSY: begin
               if (!uart_busy) begin
                  done  <= NREQ'(1) << active_id;
                  state <= GAP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
